// File: rtl/mem_req_ctrl.sv
// Request controller for the 4-entry register memory. It sequences 1-4 beat read/write bursts
// with address wrap-around and handles back-pressure on the request, write-data and response
// channels. Optional write read-back verification is enabled by defining MEM_REQ_CTRL_RDBACK_EN,
// which adds a one-cycle VFY state after each write beat and a sticky wr_err output.
module mem_req_ctrl #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [1:0]    req_len,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_last,
    output logic          busy,
    output logic          mem_sel,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_REQ_CTRL_RDBACK_EN
    ,
    output logic          wr_err
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StRsp
`ifdef MEM_REQ_CTRL_RDBACK_EN
        ,
        StVfy
`endif
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    beats_q, beats_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_last_q, rsp_last_d;
`ifdef MEM_REQ_CTRL_RDBACK_EN
    logic [DW-1:0] vdata_q, vdata_d;
    logic          wr_err_q, wr_err_d;
`endif

    // Next-state: burst sequencing, address/beat bookkeeping and registered response
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        beats_d     = beats_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
`ifdef MEM_REQ_CTRL_RDBACK_EN
        vdata_d     = vdata_q;
        wr_err_d    = wr_err_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = req_wr ? StWr : StRd;
                    addr_d  = req_addr;
                    beats_d = req_len;
`ifdef MEM_REQ_CTRL_RDBACK_EN
                    wr_err_d = 1'b0;
`endif
                end
            end
            StWr: begin
                if (wd_valid) begin
`ifdef MEM_REQ_CTRL_RDBACK_EN
                    // Hold the address; advance only after the read-back cycle
                    vdata_d = wd_data;
                    state_d = StVfy;
`else
                    if (beats_q == 2'd0) begin
                        state_d = StIdle;
                    end else begin
                        beats_d = beats_q - 2'd1;
                        addr_d  = addr_q + AW'(1);
                    end
`endif
                end
            end
`ifdef MEM_REQ_CTRL_RDBACK_EN
            StVfy: begin
                if (mem_rdata != vdata_q) begin
                    wr_err_d = 1'b1;
                end
                if (beats_q == 2'd0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWr;
                    beats_d = beats_q - 2'd1;
                    addr_d  = addr_q + AW'(1);
                end
            end
`endif
            StRd: begin
                rsp_data_d  = mem_rdata;
                rsp_valid_d = 1'b1;
                rsp_last_d  = (beats_q == 2'd0);
                state_d     = StRsp;
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rsp_last_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StRd;
                        beats_d = beats_q - 2'd1;
                        addr_d  = addr_q + AW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered response outputs; reset abandons any burst in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            beats_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
`ifdef MEM_REQ_CTRL_RDBACK_EN
            vdata_q     <= '0;
            wr_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beats_q     <= beats_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
`ifdef MEM_REQ_CTRL_RDBACK_EN
            vdata_q     <= vdata_d;
            wr_err_q    <= wr_err_d;
`endif
        end
    end

    // Memory pins and channel readies decoded from the current state
    always_comb begin
        req_ready = (state_q == StIdle);
        busy      = (state_q != StIdle);
        wd_ready  = 1'b0;
        mem_sel   = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = '0;
        case (state_q)
            StWr: begin
                wd_ready  = 1'b1;
                mem_wr    = 1'b1;
                mem_sel   = wd_valid;
                mem_wdata = wd_data;
            end
            StRd: mem_sel = 1'b1;
`ifdef MEM_REQ_CTRL_RDBACK_EN
            StVfy: mem_sel = 1'b1;
`endif
            default: ;
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;
`ifdef MEM_REQ_CTRL_RDBACK_EN
    assign wr_err    = wr_err_q;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: a behavioural 4x16 memory on the DUT pins plus a
// reference array updated from burst rules (start address plus beat index, modulo depth).
module tb_mem_req_ctrl;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 2;
`ifdef MEM_REQ_CTRL_RDBACK_EN
    localparam int BeatCyc = 2;
`else
    localparam int BeatCyc = 1;
`endif

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_len = '0;
    logic          wd_valid = 1'b0, wd_ready;
    logic [DW-1:0] wd_data = '0;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_last, busy;
    logic [DW-1:0] rsp_data;
    logic          mem_sel, mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_REQ_CTRL_RDBACK_EN
    logic          wr_err;
`endif

    logic [DW-1:0] mem [4];
    logic [DW-1:0] ref_mem [4];
    bit            corrupt = 1'b0;
    int            sel_cnt = 0;
    int            n_tests = 0;
    int            n_fail = 0;

    always #5 clk = ~clk;

    mem_req_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .wd_valid  (wd_valid),
        .wd_ready  (wd_ready),
        .wd_data   (wd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_last  (rsp_last),
        .busy      (busy),
        .mem_sel   (mem_sel),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MEM_REQ_CTRL_RDBACK_EN
        ,
        .wr_err    (wr_err)
`endif
    );

    // Behavioural register memory: synchronous write, combinational read
    always @(posedge clk) begin
        if (mem_sel && mem_wr) mem[mem_addr] <= mem_wdata;
        if (mem_sel) sel_cnt <= sel_cnt + 1;
    end
    assign mem_rdata = (mem_sel && !mem_wr) ? (mem[mem_addr] ^ DW'(corrupt)) : '0;

    task automatic do_write(input logic [AW-1:0] addr, input logic [1:0] len,
                            input logic [DW-1:0] data [4], input int gap_beat,
                            input int gap_len, input bit bad_vfy);
        int s0;
        logic [AW-1:0] a;
        s0 = sel_cnt;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = addr; req_len = len;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_req_ready got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = AW'($urandom); req_len = 2'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            if (i == gap_beat) begin
                for (int g = 0; g < gap_len; g++) begin
                    wd_valid = 1'b0; wd_data = DW'($urandom);
                    @(negedge clk);
                    n_tests++;
                    if ({mem_sel, mem_addr, busy} !== {1'b0, a, 1'b1}) begin
                        n_fail++;
                        $display("FAIL wr_gap got sel=%b addr=%0d busy=%b want 0/%0d/1",
                                 mem_sel, mem_addr, busy, a);
                    end
                    @(posedge clk); #1;
                end
            end
            wd_valid = 1'b1; wd_data = data[i];
            @(negedge clk);
            n_tests++;
            if ({mem_sel, mem_wr, wd_ready, mem_addr, mem_wdata} !==
                {1'b1, 1'b1, 1'b1, a, data[i]}) begin
                n_fail++;
                $display("FAIL wr_beat%0d got sel=%b wr=%b rdy=%b addr=%0d wdata=%h want 1/1/1/%0d/%h",
                         i, mem_sel, mem_wr, wd_ready, mem_addr, mem_wdata, a, data[i]);
            end
            @(posedge clk); #1;
            wd_valid = 1'b0;
            ref_mem[a] = data[i];
`ifdef MEM_REQ_CTRL_RDBACK_EN
            corrupt = bad_vfy;
            @(negedge clk);
            n_tests++;
            if ({mem_sel, mem_wr, wd_ready, mem_addr} !== {1'b1, 1'b0, 1'b0, a}) begin
                n_fail++;
                $display("FAIL vfy_beat%0d got sel=%b wr=%b rdy=%b addr=%0d want 1/0/0/%0d",
                         i, mem_sel, mem_wr, wd_ready, mem_addr, a);
            end
            @(posedge clk); #1;
            corrupt = 1'b0;
`else
            if (bad_vfy) corrupt = 1'b0;
`endif
        end
        @(negedge clk);
        n_tests++;
        if ({busy, req_ready} !== 2'b01 || (sel_cnt - s0) != BeatCyc * (int'(len) + 1)) begin
            n_fail++;
            $display("FAIL wr_done got busy=%b rdy=%b sel_cycles=%0d want 0/1/%0d",
                     busy, req_ready, sel_cnt - s0, BeatCyc * (int'(len) + 1));
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [1:0] len,
                           input int stall_beat, input int stall_len);
        int s0;
        logic [AW-1:0] a;
        logic [DW-1:0] exp;
        logic last;
        s0 = sel_cnt;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = addr; req_len = len; rsp_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_req_ready got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = AW'($urandom); req_len = 2'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + AW'(i);
            exp = ref_mem[a];
            last = (i == int'(len));
            @(negedge clk);
            n_tests++;
            if ({mem_sel, mem_wr, mem_addr, mem_wdata, rsp_valid, req_ready} !==
                {1'b1, 1'b0, a, DW'(0), 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rd_cycle%0d got sel=%b wr=%b addr=%0d wdata=%h vld=%b rdy=%b want 1/0/%0d/0/0/0",
                         i, mem_sel, mem_wr, mem_addr, mem_wdata, rsp_valid, req_ready, a);
            end
            @(posedge clk); #1;
            if (i == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    n_tests++;
                    if ({rsp_valid, rsp_data, rsp_last, mem_sel, mem_addr} !==
                        {1'b1, exp, last, 1'b0, a}) begin
                        n_fail++;
                        $display("FAIL rsp_stall%0d got vld=%b data=%h last=%b sel=%b addr=%0d want 1/%h/%b/0/%0d",
                                 i, rsp_valid, rsp_data, rsp_last, mem_sel, mem_addr, exp, last, a);
                    end
                    @(posedge clk); #1;
                end
            end
            rsp_ready = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({rsp_valid, rsp_data, rsp_last, mem_sel} !== {1'b1, exp, last, 1'b0}) begin
                n_fail++;
                $display("FAIL rsp_beat%0d got vld=%b data=%h last=%b sel=%b want 1/%h/%b/0",
                         i, rsp_valid, rsp_data, rsp_last, mem_sel, exp, last);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end
        @(negedge clk);
        n_tests++;
        if ({busy, rsp_valid} !== 2'b00 || (sel_cnt - s0) != int'(len) + 1) begin
            n_fail++;
            $display("FAIL rd_done got busy=%b vld=%b sel_cycles=%0d want 0/0/%0d",
                     busy, rsp_valid, sel_cnt - s0, int'(len) + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #3;
        n_tests++;
        if ({req_ready, busy, rsp_valid, rsp_data, rsp_last, mem_sel, mem_wr, mem_wdata, wd_ready}
            !== {1'b1, 1'b0, 1'b0, DW'(0), 1'b0, 1'b0, 1'b0, DW'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL reset got rdy=%b busy=%b vld=%b data=%h last=%b sel=%b wr=%b wdata=%h wdrdy=%b want 1/0/0/0/0/0/0/0/0",
                     req_ready, busy, rsp_valid, rsp_data, rsp_last, mem_sel, mem_wr, mem_wdata,
                     wd_ready);
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        logic [DW-1:0] d [4];
        d = '{16'hBEEF, 16'h0, 16'h0, 16'h0};
        do_write(2'd2, 2'd0, d, 9, 0, 1'b0);
        do_read(2'd2, 2'd0, 9, 0);
    endtask

    task automatic test_wrap_burst();
        logic [DW-1:0] d [4];
        d = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        do_write(2'd3, 2'd3, d, 9, 0, 1'b0);
        do_read(2'd3, 2'd3, 9, 0);
    endtask

    task automatic test_rsp_backpressure();
        do_read(2'd3, 2'd3, 1, 5);
    endtask

    task automatic test_wd_gaps();
        logic [DW-1:0] d [4];
        d = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        do_write(2'd1, 2'd3, d, 2, 3, 1'b0);
        do_read(2'd0, 2'd3, 9, 0);
    endtask

    task automatic test_reset_mid_burst();
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 2'd0; req_len = 2'd3; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rsp_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[1]) begin
            n_fail++;
            $display("FAIL rst_pre got vld=%b data=%h want 1/%h", rsp_valid, rsp_data, ref_mem[1]);
        end
        #2 rstn = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, mem_sel, busy, req_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL rst_async got vld=%b sel=%b busy=%b rdy=%b want 0/0/0/1",
                     rsp_valid, mem_sel, busy, req_ready);
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_tests++;
            if ({rsp_valid, mem_sel, req_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL rst_after%0d got vld=%b sel=%b rdy=%b want 0/0/1",
                         i, rsp_valid, mem_sel, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
    endtask

`ifdef MEM_REQ_CTRL_RDBACK_EN
    task automatic test_readback();
        logic [DW-1:0] d [4];
        d = '{16'h5A5A, 16'h0, 16'h0, 16'h0};
        do_write(2'd0, 2'd0, d, 9, 0, 1'b0);
        n_tests++;
        if (wr_err !== 1'b0) begin n_fail++; $display("FAIL rb_clean got %b want 0", wr_err); end
        do_write(2'd1, 2'd0, d, 9, 0, 1'b1);
        repeat (3) begin @(posedge clk); #1; end
        n_tests++;
        if (wr_err !== 1'b1) begin n_fail++; $display("FAIL rb_sticky got %b want 1", wr_err); end
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 2'd1; req_len = 2'd0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (wr_err !== 1'b0) begin n_fail++; $display("FAIL rb_clear got %b want 0", wr_err); end
        repeat (3) begin @(posedge clk); #1; end
        rsp_ready = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [DW-1:0] d [4];
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 4; k++) d[k] = DW'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_write(AW'($urandom), 2'($urandom), d, int'($urandom_range(0, 5)),
                         int'($urandom_range(0, 3)), 1'b0);
            else
                do_read(AW'($urandom), 2'($urandom), int'($urandom_range(0, 5)),
                        int'($urandom_range(0, 4)));
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_single();
        test_wrap_burst();
        test_rsp_backpressure();
        test_wd_gaps();
        test_reset_mid_burst();
`ifdef MEM_REQ_CTRL_RDBACK_EN
        test_readback();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Request controller that sits directly upstream of the team's 4-entry x 16-bit register memory and is the only agent driving its sel/wr/addr/wdata pins.
- Accepts read/write burst commands on a valid/ready request channel and write data on a separate valid/ready data channel.
- Returns read data on a valid/ready response channel with a last flag.
- Sequences bursts of 1-4 beats with address wrap-around, and handles back-pressure on every channel.

Parameters:
- DW, 16, data width; must match the memory word width.
- AW, 2, address width; the memory depth is 2**AW words.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  asynchronous active-low reset
- req_valid  in  1  command present
- req_ready  out  1  command accepted when high together with req_valid
- req_wr  in  1  1 = write burst, 0 = read burst
- req_addr  in  AW  start address
- req_len  in  2  number of beats minus 1 (0..3)
- wd_valid  in  1  write data present
- wd_ready  out  1  write data accepted
- wd_data  in  DW  write beat data
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  read data consumed
- rsp_data  out  DW  read beat data
- rsp_last  out  1  final beat of burst
- busy  out  1  high whenever state is not IDLE
- mem_sel  out  1  to memory sel
- mem_wr  out  1  to memory wr
- mem_addr  out  AW  to memory addr
- mem_wdata  out  DW  to memory wdata
- mem_rdata  in  DW  from memory rdata; combinational, valid while sel=1 and wr=0

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, cur_addr=0, beats_left=0, rsp_valid=0, rsp_data=0, rsp_last=0.
  - Combinational outputs during reset: mem_sel=0, mem_wr=0, mem_wdata=0, wd_ready=0, busy=0, req_ready=1.
  - Reset mid-burst abandons the burst; no partial response is issued after release.
- States: IDLE, WR, RD, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_wr, cur_addr<=req_addr, beats_left<=req_len, then go to WR or RD.
- WR:
  - wd_ready=1; mem_wr=1; mem_addr=cur_addr; mem_wdata=wd_data; mem_sel=wd_valid (combinational).
  - The memory captures the word on the same edge as the wd handshake.
  - On handshake: if beats_left==0, go to IDLE; else beats_left-1 and cur_addr+1 modulo 2**AW (3 wraps to 0).
  - With no handshake: stay in WR, cur_addr unchanged, no memory write.
- RD:
  - Exactly one cycle long; mem_sel=1, mem_wr=0, mem_addr=cur_addr.
  - On the edge: rsp_data<=mem_rdata, rsp_valid<=1, rsp_last<=(beats_left==0); go to RSP.
- RSP:
  - mem_sel=0, mem_wr=0.
  - rsp_valid, rsp_data and rsp_last held stable until rsp_ready.
  - On the handshake edge: rsp_valid<=0.
    - If rsp_last: go to IDLE.
    - Else: beats_left-1, cur_addr+1 (wrapping), go to RD.
- Latency:
  - Read beat: 2 cycles minimum (RD then RSP).
  - Command accept to first response valid: 2 cycles.
  - Write beat: 1 cycle per handshake.
- mem_wr is 0 in every state except WR. mem_wdata is 0 outside WR.
- req_ready is 0 in every state except IDLE. A new command is never accepted in the same cycle the previous burst completes.
- Both bursts and single-beat commands behave identically apart from the beat count.

Optional Feature:
- Macro: MEM_REQ_CTRL_RDBACK_EN.
- Defined:
  - Adds a VFY state and an output port wr_err (1 bit, reset 0).
  - After each WR handshake: latch wd_data, enter VFY for one cycle with mem_sel=1, mem_wr=0, mem_addr = address just written, wd_ready=0.
  - Compare mem_rdata with the latched data; a mismatch sets wr_err sticky.
  - Then advance address/beats as in WR: go to WR, or to IDLE after the last beat.
  - wr_err clears on reset or on acceptance of the next command.
  - Write beat costs 2 cycles.
- Undefined: no VFY state, no wr_err port, 1-cycle write beats.

Test Plan:
- Single write: addr=2, len=0, data=0x BEEF. Then single read addr=2 -> rsp_data=0xBEEF, rsp_last=1, mem_sel high exactly 1 cycle for each operation.
- Wrap burst: write addr=3, len=3, data 0x1111/0x2222/0x3333/0x4444 -> mem_addr sequence 3,0,1,2. Then read burst addr=3, len=3 -> same data in order, rsp_last only on the 4th beat, busy low afterwards.
- Response back-pressure: rsp_ready low 5 cycles on beat 1 -> rsp_valid=1, rsp_data stable, mem_sel=0 throughout, no address advance.
- Write data gaps: wd_valid low 3 cycles mid-burst -> mem_sel=0 during the gap, mem_addr constant, final memory contents correct.
- Reset mid-burst: rstn low during RSP of beat 2 of 4 -> rsp_valid=0 and mem_sel=0 immediately (asynchronous). After release req_ready=1 and no further responses.
- Readback (macro defined): write 0x5A5A -> 2 cycles per beat, wr_err=0. Force mem_rdata to 0x5A5B during VFY -> wr_err=1, held until next command accepted.
